// File: rtl/usr_gen2.sv
// usr_gen2 -- multi-step universal shift register with a start/busy/done handshake.
//
// A request (start while not busy) captures the operation mode and step count.
// The register then applies that operation once per clock until the count is
// used up, and pulses done for one cycle afterwards.
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   CNT_W  width of the step-count input (2^CNT_W-1 >= WIDTH)
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   in     parallel load data (mode 011)
//   s      operation mode, captured on an accepted start
//   sir    serial input entering the MSB on a right shift, read at each step
//   sil    serial input entering the LSB on a left shift, read at each step
//   start  operation request, accepted only while busy is low
//   count  number of steps, captured on an accepted start
//   out    register contents
//   sor    out[0], the bit a right shift discards next
//   sol    out[WIDTH-1], the bit a left shift discards next
//   busy   high while steps are executing
//   done   one-cycle pulse after the final step
module usr_gen2 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       s,
  input  logic             sir,
  input  logic             sil,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             sor,
  output logic             sol,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_t           state, state_nxt;
  logic [2:0]       mode, mode_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [WIDTH-1:0] out_nxt;

  // One application of an operation to the current register value.
  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             si_r,
    input logic             si_l
  );
    case (m)
      M_SHR:   step_op = {si_r, v[WIDTH-1:1]};
      M_SHL:   step_op = {v[WIDTH-2:0], si_l};
      M_LOAD:  step_op = ld;
      M_ROR:   step_op = {v[0], v[WIDTH-1:1]};
      M_ROL:   step_op = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ASR:   step_op = {v[WIDTH-1], v[WIDTH-1:1]};
      M_CLR:   step_op = '0;
      default: step_op = v;
    endcase
  endfunction

  // Hold, load and clear are idempotent, so they always run exactly one step.
  function automatic logic is_single_step(input logic [2:0] m);
    is_single_step = (m == M_HOLD) || (m == M_LOAD) || (m == M_CLR);
  endfunction

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode;
    remaining_nxt = remaining;
    out_nxt       = out;
    case (state)
      RUN: begin
        out_nxt       = step_op(mode, out, in, sir, sil);
        remaining_nxt = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) state_nxt = DONE;
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise lasts one cycle.
        if (state == DONE) state_nxt = IDLE;
        if (start) begin
          mode_nxt = s;
          if (is_single_step(s)) begin
            remaining_nxt = CNT_W'(1);
            state_nxt     = RUN;
          end else if (count == '0) begin
            // Zero-step shift/rotate: nothing to do, report completion directly.
            remaining_nxt = '0;
            state_nxt     = DONE;
          end else begin
            remaining_nxt = count;
            state_nxt     = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode      <= M_HOLD;
      remaining <= '0;
      out       <= '0;
    end else begin
      state     <= state_nxt;
      mode      <= mode_nxt;
      remaining <= remaining_nxt;
      out       <= out_nxt;
    end
  end

  assign sor  = out[0];
  assign sol  = out[WIDTH-1];
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_usr_gen2.sv
// tb_usr_gen2 -- self-checking bench for usr_gen2 (WIDTH=4, CNT_W=3).
// A transaction-level model tracks the register value, steps still owed and the
// done pulse; every scenario compares the DUT against it and against the
// literal values worked out for the directed sequences.
module tb_usr_gen2;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in    = '0;
  logic [2:0]       s     = '0;
  logic             sir   = 1'b0;
  logic             sil   = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic [WIDTH-1:0] out;
  logic             sor, sol, busy, done;

  usr_gen2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in(in), .s(s), .sir(sir), .sil(sil),
    .start(start), .count(count), .out(out), .sor(sor), .sol(sol),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: register value, steps still owed, done flag.
  logic [WIDTH-1:0] m_out  = '0;
  int               m_left = 0;
  logic [2:0]       m_mode = '0;
  logic             m_done = 1'b0;

  wire [WIDTH+3:0] act = {out, sor, sol, busy, done};

  function automatic logic [WIDTH-1:0] ref_apply(input logic [2:0] m, input logic [WIDTH-1:0] val,
                                                 input logic [WIDTH-1:0] ld, input logic si_r, input logic si_l);
    int v    = int'(val);
    int mask = (1 << WIDTH) - 1;
    int r;
    case (m)
      3'd1:    r = (int'(si_r) << (WIDTH - 1)) | (v >> 1);
      3'd2:    r = ((v << 1) | int'(si_l)) & mask;
      3'd3:    r = int'(ld);
      3'd4:    r = ((v >> 1) | (v << (WIDTH - 1))) & mask;
      3'd5:    r = ((v << 1) | (v >> (WIDTH - 1))) & mask;
      3'd6:    r = (v >> 1) | (v & (1 << (WIDTH - 1)));
      3'd7:    r = 0;
      default: r = v;
    endcase
    return WIDTH'(r);
  endfunction

  function automatic logic [WIDTH+3:0] exp_vec();
    return {m_out, m_out[0], m_out[WIDTH-1], (m_left > 0), m_done};
  endfunction

  task automatic model_clear();
    m_out  = '0;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    if (m_left > 0) begin
      m_out  = ref_apply(m_mode, m_out, in, sir, sil);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_mode = s;
        m_left = (s == 3'd0 || s == 3'd3 || s == 3'd7) ? 1 : int'(count);
        if (m_left == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (act !== exp_vec() || act !== '0)
      $display("FAIL reset_async act=%b exp=%b", act, exp_vec());
    if (act !== exp_vec() || act !== '0) miscompares++;
    #1 reset = 1'b1;
  endtask

  task automatic test_load_hold();
    int dn = 0;
    s = 3'b011; in = 4'b0011; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); start = 1'b0;
      dn += int'(done);
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL load_step%0d act=%b exp=%b", i, act, exp_vec());
      end
      if (i == 0 && busy !== 1'b1) begin
        miscompares++; $display("FAIL load_busy act=%b exp=1", busy);
      end
    end
    vectors++;
    if (out !== 4'b0011 || dn != 1) begin
      miscompares++;
      $display("FAIL load_result out=%b done_pulses=%0d exp out=0011 pulses=1", out, dn);
    end
    s = 3'b000; in = 4'b1111; start = 1'b1;
    tick(); start = 1'b0; tick(); tick();
    vectors++;
    if (out !== 4'b0011 || act !== exp_vec()) begin
      miscompares++;
      $display("FAIL hold_result act=%b exp=%b", act, exp_vec());
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] e_out [3] = '{4'b0011, 4'b1001, 4'b1100};
    logic       e_sor [3] = '{1'b1, 1'b1, 1'b0};
    logic       e_bsy [3] = '{1'b1, 1'b1, 1'b0};
    logic       e_dn  [3] = '{1'b0, 1'b0, 1'b1};
    s = 3'b001; count = 3'd2; sir = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); start = 1'b0;
      vectors++;
      if (act !== exp_vec() || out !== e_out[i] || sor !== e_sor[i] || busy !== e_bsy[i] || done !== e_dn[i]) begin
        miscompares++;
        $display("FAIL shr_step%0d act=%b exp=%b literal out=%b", i, act, exp_vec(), e_out[i]);
      end
    end
    tick();
  endtask

  task automatic test_rotate();
    logic [3:0] e_out [5] = '{4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100};
    s = 3'b101; count = 3'd4; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      // A request while busy must be ignored.
      start = (i == 0); s = (i == 0) ? 3'b011 : 3'b101; in = 4'b0000;
      vectors++;
      if (act !== exp_vec() || out !== e_out[i] || done !== (i == 4)) begin
        miscompares++;
        $display("FAIL rol_step%0d act=%b exp=%b literal out=%b", i, act, exp_vec(), e_out[i]);
      end
    end
    tick();
    s = 3'b100; count = 3'd0; start = 1'b1;
    tick(); start = 1'b0;
    vectors++;
    if (act !== exp_vec() || out !== 4'b1100 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ror_zero act=%b exp=%b", act, exp_vec());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_out [3] = '{4'b1100, 4'b1110, 4'b1111};
    int dn = 0;
    s = 3'b011; in = 4'b1000; start = 1'b1;
    tick(); start = 1'b0; tick(); tick();
    s = 3'b110; count = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      dn += int'(done);
      vectors++;
      if (act !== exp_vec() || out !== e_out[i]) begin
        miscompares++;
        $display("FAIL asr_step%0d act=%b exp=%b literal out=%b", i, act, exp_vec(), e_out[i]);
      end
    end
    s = 3'b111; start = 1'b1;
    tick(); start = 1'b0;
    dn += int'(done);
    tick();
    dn += int'(done);
    vectors++;
    if (act !== exp_vec() || out !== 4'b0000 || dn != 2) begin
      miscompares++;
      $display("FAIL b2b_clear act=%b exp=%b done_pulses=%0d exp=2", act, exp_vec(), dn);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int dn = 0;
    s = 3'b011; in = 4'b0001; start = 1'b1;
    tick(); start = 1'b0; tick(); tick();
    s = 3'b010; count = 3'd5; sil = 1'b0; start = 1'b1;
    tick(); start = 1'b0; tick(); tick();
    vectors++;
    if (out !== 4'b0100 || act !== exp_vec()) begin
      miscompares++; $display("FAIL abort_pre act=%b exp=%b", act, exp_vec());
    end
    #2 reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (act !== '0) begin
      miscompares++; $display("FAIL abort_reset act=%b exp=%b", act, {(WIDTH+4){1'b0}});
    end
    for (int i = 0; i < 2; i++) begin
      tick(); dn += int'(done) + int'(busy);
    end
    reset = 1'b1;
    s = 3'b011; in = 4'b1010; start = 1'b1;
    tick(); start = 1'b0; tick();
    vectors++;
    if (act !== exp_vec() || out !== 4'b1010 || done !== 1'b1 || dn != 0) begin
      miscompares++;
      $display("FAIL abort_reload act=%b exp=%b stray=%0d", act, exp_vec(), dn);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      s     = 3'($urandom_range(0, 7));
      count = 3'($urandom_range(0, 7));
      sir   = 1'($urandom_range(0, 1));
      sil   = 1'($urandom_range(0, 1));
      if (m_left == 0) in = 4'($urandom_range(0, 15));
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL random%0d act=%b exp=%b", i, act, exp_vec());
      end
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (act !== exp_vec()) begin
          miscompares++;
          $display("FAIL random_reset%0d act=%b exp=%b", i, act, exp_vec());
        end
        #1 reset = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_shift_right();
    test_rotate();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usr_gen2.md
USR_GEN2 -- requirements
Module: usr_gen2

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits (>=2).
REQ-002 Parameter CNT_W, default 3, width of step-count input; SHALL satisfy 2^CNT_W-1 >= WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in  input  WIDTH  parallel load data.
REQ-006 s  input  3  operation mode, sampled only on accepted start.
REQ-007 sir  input  1  serial-in for right shift (enters MSB), sampled every step cycle.
REQ-008 sil  input  1  serial-in for left shift (enters LSB), sampled every step cycle.
REQ-009 start  input  1  operation request, accepted when busy=0.
REQ-010 count  input  CNT_W  number of steps, sampled only on accepted start.
REQ-011 out  output  WIDTH  register contents.
REQ-012 sor  output  1  equals out[0] (next bit lost on right shift).
REQ-013 sol  output  1  equals out[WIDTH-1] (next bit lost on left shift).
REQ-014 busy  output  1  high while steps are executing.
REQ-015 done  output  1  one-cycle pulse after the final step of an operation.

Function
REQ-016 Mode encoding SHALL be: 000 hold, 001 shift right {sir,out[W-1:1]}, 010 shift left {out[W-2:0],sil}, 011 parallel load in, 100 rotate right, 101 rotate left, 110 arithmetic shift right (MSB replicated), 111 clear to 0.
REQ-017 FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-018 On a rising edge with start=1 and busy=0 (IDLE or DONE), s and count SHALL be captured and the FSM SHALL enter RUN with remaining=count; out unchanged on that edge.
REQ-019 Modes 000, 011, 111 SHALL force remaining=1 regardless of count.
REQ-020 Shift/rotate modes with count=0 SHALL go directly to DONE; out unchanged.
REQ-021 Each edge in RUN SHALL apply the captured mode exactly once and decrement remaining; when remaining reaches 0 the FSM SHALL enter DONE.
REQ-022 Latency: N-step operation keeps busy high exactly N cycles; done high the following cycle; out final at the edge that enters DONE.
REQ-023 DONE SHALL last one cycle, then IDLE, unless start=1 in DONE, which enters RUN (back-to-back, done still pulses).
REQ-024 start while busy=1 SHALL be ignored; no queuing, no effect on captured mode/count.
REQ-025 In IDLE and DONE out SHALL hold its value; s, in, count changes SHALL have no effect.
REQ-026 sir/sil SHALL be sampled live at each step edge, allowing a different serial bit per step.
REQ-027 Rotate by count=WIDTH SHALL return the original value; count>WIDTH SHALL continue wrapping modulo WIDTH.
REQ-028 sor/sol SHALL be combinational from out, no extra register.

Reset
REQ-029 reset=0 SHALL immediately, independent of clk, force out=0, FSM=IDLE, busy=0, done=0, remaining=0.
REQ-030 reset asserted mid-operation SHALL abort it with no done pulse; first start after release behaves as from power-up.
REQ-031 start high on the first edge after reset release SHALL be accepted normally.

Verification (WIDTH=4, CNT_W=3)
REQ-032 reset=0 at any time -> out=0000, sor=0, sol=0, busy=0, done=0 without a clock edge.
REQ-033 s=011, in=0011, start one cycle -> busy 1 cycle, out=0011, done pulses once; s=000 start -> out stays 0011.
REQ-034 from 0011, s=001, count=2, sir=1 -> out 1001 then 1100, sor 1,1,0, busy exactly 2 cycles, then done.
REQ-035 from 1100, s=101, count=4 -> out 1001,0011,0110,1100; start pulsed during busy ignored; s=100 count=0 -> done next cycle, out unchanged.
REQ-036 from 1000, s=110, count=3 -> out 1100,1110,1111; back-to-back start in DONE with s=111 -> out=0000, second done pulse.
REQ-037 from 0001, s=010, count=5, sil=0, reset low after 2 steps -> out=0000 immediately, busy=0, no done; after release s=011 in=1010 -> out=1010.
